ahb_slave_bridge: RTL and testbench

AHB_SLAVE_BRIDGE -- requirements
Module: ahb_slave_bridge

---
 rtl/ahb_slave_bridge.sv | 146 ++++++++++++++
 tb/tb_ahb_slave_bridge.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_bridge.sv
// AHB-Lite slave to native valid/ready request/response bridge.
// Ports: AHB slave side (h*), native request (req_*) and response (rsp_*).
module ahb_slave_bridge #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  hsel_i,
  input  logic                  hready_i,
  input  logic [1:0]            htrans_i,
  input  logic [2:0]            hsize_i,
  input  logic [2:0]            hburst_i,
  input  logic                  hwrite_i,
  input  logic [ADDR_WIDTH-1:0] haddr_i,
  input  logic [31:0]           hwdata_i,
  output logic                  hready_o,
  output logic [1:0]            hresp_o,
  output logic [31:0]           hrdata_o,
  output logic                  req_vld_o,
  input  logic                  req_rdy_i,
  output logic                  req_wr_o,
  output logic [ADDR_WIDTH-1:0] req_addr_o,
  output logic [2:0]            req_size_o,
  output logic [31:0]           req_wdata_o,
  output logic [3:0]            req_wstrb_o,
  input  logic                  rsp_vld_i,
  input  logic [31:0]           rsp_rdata_i,
  input  logic                  rsp_err_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RSP,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic       can_accept;
  logic       accept;
  logic       illegal;
  logic [3:0] wstrb_d;
  logic       unused;

  // Burst type and BUSY/SEQ distinction carry no meaning here.
  assign unused = ^{hburst_i, htrans_i[0]};

  assign can_accept = (state_q == S_IDLE)
                    | (state_q == S_DONE)
                    | (state_q == S_ERR2);

  assign accept = can_accept & hsel_i
                & hready_i & htrans_i[1];

  assign req_wdata_o = hwdata_i;

  always_comb begin
    illegal = 1'b0;
    unique case (hsize_i)
      3'd0:    illegal = 1'b0;
      3'd1:    illegal = haddr_i[0];
      3'd2:    illegal = |haddr_i[1:0];
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    wstrb_d = 4'h0;
    if (hwrite_i) begin
      unique case (hsize_i)
        3'd0:    wstrb_d = 4'b0001 << haddr_i[1:0];
        3'd1:    wstrb_d = 4'b0011 << {haddr_i[1], 1'b0};
        default: wstrb_d = 4'hF;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    hready_o  = 1'b1;
    hresp_o   = 2'b00;
    req_vld_o = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR2: begin
        if (state_q == S_ERR2) begin
          hresp_o = 2'b01;
        end
        if (accept) begin
          state_d = illegal ? S_ERR1 : S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        hready_o  = 1'b0;
        req_vld_o = 1'b1;
        if (req_rdy_i) begin
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        hready_o = 1'b0;
        if (rsp_vld_i) begin
          state_d = rsp_err_i ? S_ERR1 : S_DONE;
        end
      end
      S_ERR1: begin
        hready_o = 1'b0;
        hresp_o  = 2'b01;
        state_d  = S_ERR2;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q     <= S_IDLE;
      hrdata_o    <= 32'h0;
      req_wr_o    <= 1'b0;
      req_addr_o  <= '0;
      req_size_o  <= 3'd0;
      req_wstrb_o <= 4'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_wr_o    <= hwrite_i;
        req_addr_o  <= haddr_i;
        req_size_o  <= hsize_i;
        req_wstrb_o <= wstrb_d;
      end
      // Only a successful read response updates read data.
      if ((state_q == S_RSP) && rsp_vld_i
          && !rsp_err_i && !req_wr_o) begin
        hrdata_o <= rsp_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_ahb_slave_bridge.sv
// Self-checking bench for ahb_slave_bridge.
// Table vectors, directed corner sequences and random transfers.
module tb_ahb_slave_bridge;

  logic        hclk;
  logic        hreset;
  logic        hsel_i;
  logic        hready_i;
  logic [1:0]  htrans_i;
  logic [2:0]  hsize_i;
  logic [2:0]  hburst_i;
  logic        hwrite_i;
  logic [15:0] haddr_i;
  logic [31:0] hwdata_i;
  logic        hready_o;
  logic [1:0]  hresp_o;
  logic [31:0] hrdata_o;
  logic        req_vld_o;
  logic        req_rdy_i;
  logic        req_wr_o;
  logic [15:0] req_addr_o;
  logic [2:0]  req_size_o;
  logic [31:0] req_wdata_o;
  logic [3:0]  req_wstrb_o;
  logic        rsp_vld_i;
  logic [31:0] rsp_rdata_i;
  logic        rsp_err_i;

  int n_chk;
  int n_fail;
  int n_req;

  ahb_slave_bridge #(.ADDR_WIDTH(16)) dut (
    .hclk(hclk), .hreset(hreset),
    .hsel_i(hsel_i), .hready_i(hready_i),
    .htrans_i(htrans_i), .hsize_i(hsize_i),
    .hburst_i(hburst_i), .hwrite_i(hwrite_i),
    .haddr_i(haddr_i), .hwdata_i(hwdata_i),
    .hready_o(hready_o), .hresp_o(hresp_o),
    .hrdata_o(hrdata_o),
    .req_vld_o(req_vld_o), .req_rdy_i(req_rdy_i),
    .req_wr_o(req_wr_o), .req_addr_o(req_addr_o),
    .req_size_o(req_size_o),
    .req_wdata_o(req_wdata_o),
    .req_wstrb_o(req_wstrb_o),
    .rsp_vld_i(rsp_vld_i),
    .rsp_rdata_i(rsp_rdata_i),
    .rsp_err_i(rsp_err_i)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  always @(posedge hclk)
    if (!hreset && req_vld_o && req_rdy_i)
      n_req <= n_req + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  // Reference rules written from the protocol, not the RTL.
  function automatic logic is_illegal(input logic [15:0] a,
                                      input logic [2:0] sz);
    int bytes;
    if (sz > 3'd2) return 1'b1;
    bytes = 1 << sz;
    return (int'(a) % bytes) != 0;
  endfunction

  function automatic logic [3:0] strb_of(input logic [15:0] a,
                                         input logic [2:0] sz,
                                         input logic wr);
    int bytes;
    int m;
    if (!wr) return 4'h0;
    bytes = 1 << sz;
    m = ((1 << bytes) - 1) << (int'(a) % 4);
    return 4'(m & 15);
  endfunction

  task automatic do_xfer(input logic [15:0] a,
                         input logic [2:0] sz,
                         input logic wr,
                         input logic [31:0] wd,
                         input logic [31:0] rd,
                         input logic rerr,
                         input int rdy_dly,
                         input int rsp_dly,
                         input logic exp_ill,
                         input logic [3:0] exp_strb,
                         input logic [31:0] exp_rd);
    hsel_i = 1; htrans_i = 2'b10;
    hsize_i = sz; hwrite_i = wr;
    haddr_i = a; hready_i = 1;
    req_rdy_i = 0; rsp_vld_i = 0;
    tick();
    hsel_i = 0; htrans_i = 2'b00;
    hwdata_i = wd;
    #1;
    if (exp_ill) begin
      chk("ill_err1_rdy", 32'(hready_o), 0);
      chk("ill_err1_resp", 32'(hresp_o), 1);
      chk("ill_no_vld", 32'(req_vld_o), 0);
      tick();
      chk("ill_err2_rdy", 32'(hready_o), 1);
      chk("ill_err2_resp", 32'(hresp_o), 1);
      tick();
    end else begin
      for (int i = 0; i <= rdy_dly; i++) begin
        chk("req_vld", 32'(req_vld_o), 1);
        chk("req_addr", 32'(req_addr_o), 32'(a));
        chk("req_size", 32'(req_size_o), 32'(sz));
        chk("req_wr", 32'(req_wr_o), 32'(wr));
        chk("req_wstrb", 32'(req_wstrb_o),
            32'(exp_strb));
        if (wr) chk("req_wdata", req_wdata_o, wd);
        chk("req_hready", 32'(hready_o), 0);
        if (i == rdy_dly) req_rdy_i = 1;
        tick();
      end
      req_rdy_i = 0;
      for (int i = 0; i < rsp_dly; i++) begin
        chk("rsp_hready", 32'(hready_o), 0);
        chk("rsp_no_vld", 32'(req_vld_o), 0);
        tick();
      end
      chk("rsp_hready", 32'(hready_o), 0);
      rsp_vld_i = 1; rsp_rdata_i = rd;
      rsp_err_i = rerr;
      tick();
      rsp_vld_i = 0; rsp_err_i = 0;
      if (rerr) begin
        chk("rerr1_rdy", 32'(hready_o), 0);
        chk("rerr1_resp", 32'(hresp_o), 1);
        tick();
        chk("rerr2_rdy", 32'(hready_o), 1);
        chk("rerr2_resp", 32'(hresp_o), 1);
        tick();
      end else begin
        chk("done_rdy", 32'(hready_o), 1);
        chk("done_resp", 32'(hresp_o), 0);
        chk("done_rdata", hrdata_o, exp_rd);
        tick();
      end
    end
    chk("idle_rdy", 32'(hready_o), 1);
    chk("idle_resp", 32'(hresp_o), 0);
    chk("idle_rdata", hrdata_o, exp_rd);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [2:0]  sz;
    logic        wr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        rerr;
    int          rdy_dly;
    int          rsp_dly;
    logic        exp_ill;
    logic [3:0]  exp_strb;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[10];

  logic [15:0] ra;
  logic [2:0]  rsz;
  logic        rwr;
  logic        rerr;
  logic [31:0] rwd;
  logic [31:0] rrd;
  logic        rill;
  logic [31:0] model_rd;
  int          req_base;

  initial begin
    tbl[0] = '{16'h0010, 3'd2, 1'b1, 32'hDEADBEEF,
               32'h0, 1'b0, 0, 0, 1'b0, 4'hF, 32'h0};
    tbl[1] = '{16'h0003, 3'd0, 1'b0, 32'h0,
               32'h11223344, 1'b0, 0, 0, 1'b0, 4'h0,
               32'h11223344};
    tbl[2] = '{16'h0001, 3'd1, 1'b1, 32'h5,
               32'h0, 1'b0, 0, 0, 1'b1, 4'h0,
               32'h11223344};
    tbl[3] = '{16'h0040, 3'd2, 1'b1, 32'hCAFEF00D,
               32'h0, 1'b0, 5, 0, 1'b0, 4'hF,
               32'h11223344};
    tbl[4] = '{16'h0006, 3'd1, 1'b1, 32'h12345678,
               32'h0, 1'b0, 1, 2, 1'b0, 4'hC,
               32'h11223344};
    tbl[5] = '{16'h0005, 3'd0, 1'b1, 32'h0000AB00,
               32'h0, 1'b0, 0, 1, 1'b0, 4'h2,
               32'h11223344};
    tbl[6] = '{16'h0008, 3'd2, 1'b0, 32'h0,
               32'h99999999, 1'b1, 0, 0, 1'b0, 4'h0,
               32'h11223344};
    tbl[7] = '{16'h0000, 3'd3, 1'b0, 32'h0,
               32'h0, 1'b0, 0, 0, 1'b1, 4'h0,
               32'h11223344};
    tbl[8] = '{16'h0002, 3'd2, 1'b0, 32'h0,
               32'h0, 1'b0, 0, 0, 1'b1, 4'h0,
               32'h11223344};
    tbl[9] = '{16'h000A, 3'd1, 1'b0, 32'h0,
               32'hA5A55A5A, 1'b0, 2, 3, 1'b0, 4'h0,
               32'hA5A55A5A};

    n_chk = 0; n_fail = 0; n_req = 0;
    hreset = 1; hsel_i = 0; hready_i = 1;
    htrans_i = 0; hsize_i = 0; hburst_i = 0;
    hwrite_i = 0; haddr_i = 0; hwdata_i = 0;
    req_rdy_i = 0; rsp_vld_i = 0;
    rsp_rdata_i = 0; rsp_err_i = 0;
    tick(); tick();
    chk("rst_hready", 32'(hready_o), 1);
    chk("rst_hresp", 32'(hresp_o), 0);
    chk("rst_hrdata", hrdata_o, 0);
    chk("rst_vld", 32'(req_vld_o), 0);
    chk("rst_wr", 32'(req_wr_o), 0);
    chk("rst_addr", 32'(req_addr_o), 0);
    chk("rst_size", 32'(req_size_o), 0);
    chk("rst_wstrb", 32'(req_wstrb_o), 0);
    hreset = 0;
    tick();

    for (int i = 0; i < 10; i++)
      do_xfer(tbl[i].a, tbl[i].sz, tbl[i].wr,
              tbl[i].wd, tbl[i].rd, tbl[i].rerr,
              tbl[i].rdy_dly, tbl[i].rsp_dly,
              tbl[i].exp_ill, tbl[i].exp_strb,
              tbl[i].exp_rd);

    // Transfers that must not be captured.
    hsel_i = 1; htrans_i = 2'b01;
    haddr_i = 16'h0100; hwrite_i = 1; hsize_i = 2;
    tick();
    chk("busy_no_vld", 32'(req_vld_o), 0);
    chk("busy_rdy", 32'(hready_o), 1);
    hsel_i = 0; htrans_i = 2'b10;
    tick();
    chk("unsel_no_vld", 32'(req_vld_o), 0);
    hsel_i = 1; hready_i = 0;
    tick();
    chk("hrdyi_no_vld", 32'(req_vld_o), 0);
    chk("hrdyi_rdy", 32'(hready_o), 1);
    hready_i = 1; hsel_i = 0; htrans_i = 0;
    // Stray response outside RSP is ignored.
    rsp_vld_i = 1; rsp_rdata_i = 32'h77777777;
    tick();
    rsp_vld_i = 0;
    tick();
    chk("stray_rsp", hrdata_o, 32'hA5A55A5A);
    chk("stray_rdy", 32'(hready_o), 1);

    // INCR4 word write burst, each beat accepted in DONE.
    req_base = n_req;
    hburst_i = 3'b011;
    hsel_i = 1; htrans_i = 2'b10; hsize_i = 2;
    hwrite_i = 1; haddr_i = 16'h0020;
    for (int b = 0; b < 4; b++) begin
      tick();
      hsel_i = 0; htrans_i = 0;
      hwdata_i = 32'h1000 + 32'(b);
      #1;
      chk("bst_vld", 32'(req_vld_o), 1);
      chk("bst_addr", 32'(req_addr_o),
          32'h20 + 32'(4 * b));
      chk("bst_wstrb", 32'(req_wstrb_o), 32'hF);
      chk("bst_wdata", req_wdata_o,
          32'h1000 + 32'(b));
      req_rdy_i = 1;
      tick();
      req_rdy_i = 0;
      chk("bst_rsp_rdy", 32'(hready_o), 0);
      rsp_vld_i = 1; rsp_err_i = 0;
      tick();
      rsp_vld_i = 0;
      chk("bst_done_rdy", 32'(hready_o), 1);
      chk("bst_done_resp", 32'(hresp_o), 0);
      if (b < 3) begin
        hsel_i = 1; htrans_i = 2'b11;
        haddr_i = 16'h0020 + 16'(4 * (b + 1));
      end
    end
    tick();
    chk("bst_nreq", 32'(n_req - req_base), 4);
    hburst_i = 0;

    // Reset while waiting for a response.
    hsel_i = 1; htrans_i = 2'b10; hsize_i = 2;
    hwrite_i = 0; haddr_i = 16'h0044;
    tick();
    hsel_i = 0; htrans_i = 0;
    req_rdy_i = 1;
    tick();
    req_rdy_i = 0;
    chk("pre_rst_rsp", 32'(hready_o), 0);
    hreset = 1;
    tick();
    hreset = 0;
    rsp_vld_i = 1; rsp_rdata_i = 32'hFFFF0000;
    chk("mrst_rdy", 32'(hready_o), 1);
    chk("mrst_rdata", hrdata_o, 0);
    chk("mrst_vld", 32'(req_vld_o), 0);
    chk("mrst_addr", 32'(req_addr_o), 0);
    tick();
    rsp_vld_i = 0;
    chk("late_rsp_rdata", hrdata_o, 0);
    chk("late_rsp_rdy", 32'(hready_o), 1);
    chk("late_rsp_resp", 32'(hresp_o), 0);

    // Random transfers against the reference rules.
    model_rd = 32'h0;
    for (int t = 0; t < 60; t++) begin
      ra = 16'($urandom);
      rsz = 3'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (rsz == 3'd1) ra[0] = 1'b0;
        if (rsz == 3'd2) ra[1:0] = 2'b00;
        if (rsz == 3'd3) rsz = 3'd2;
        if (rsz == 3'd2) ra[1:0] = 2'b00;
      end
      rwr = 1'($urandom);
      rwd = $urandom;
      rrd = $urandom;
      rerr = ($urandom_range(0, 7) == 0);
      rill = is_illegal(ra, rsz);
      if (!rill && !rerr && !rwr) model_rd = rrd;
      do_xfer(ra, rsz, rwr, rwd, rrd, rerr,
              int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)),
              rill, strb_of(ra, rsz, rwr), model_rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
